// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, redirect mux and IF/ID pipeline register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined; otherwise they read as 0.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             PC_write_i,
  input  logic             IF_ID_write_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      IF_ID_pc4_o,
  output logic [31:0]      IF_ID_instr_o,
  output logic             IF_ID_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic            run_q, run_eff;
  if_id_t          if_id_q, if_id_d;

  // The arming cycle itself already fetches, so start_i is folded into the run decision.
  assign run_eff  = run_q | start_i;
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-PC selection: redirect beats stall hold beats sequential fetch.
  always_comb begin
    pc_d = pc_q;
    if (run_eff) begin
      if (redirect_i)      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      else if (PC_write_i) pc_d = pc_plus4;
    end
  end

  // IF/ID next value: flush inserts a bubble even when the register is being held.
  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d = '{pc4: NOP, instr: NOP, valid: 1'b0};
    end else if (IF_ID_write_i) begin
      if (run_eff) if_id_d = '{pc4: pc_plus4, instr: imem_data_i, valid: 1'b1};
      else         if_id_d = '{pc4: NOP, instr: NOP, valid: 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      run_q   <= 1'b0;
      if_id_q <= '{pc4: NOP, instr: NOP, valid: 1'b0};
    end else begin
      pc_q    <= pc_d;
      run_q   <= run_eff;
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign IF_ID_pc4_o   = if_id_q.pc4;
  assign IF_ID_instr_o = if_id_q.instr;
  assign IF_ID_valid_o = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (run_eff && !PC_write_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_i && flush_cnt_q != '1)                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; expected values are hand-computed from the fetch rules.
module tb_if_stage;

  localparam int unsigned CNT_W = 3;
`ifdef IF_PERF_CNT_EN
  localparam int unsigned PERF = 1;
`else
  localparam int unsigned PERF = 0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, PC_write_i, IF_ID_write_i, flush_i, redirect_i;
  logic [31:0]      redirect_pc_i, imem_addr_o, imem_data_i, IF_ID_pc4_o, IF_ID_instr_o;
  logic             IF_ID_valid_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .PC_write_i(PC_write_i),
    .IF_ID_write_i(IF_ID_write_i), .flush_i(flush_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .IF_ID_pc4_o(IF_ID_pc4_o), .IF_ID_instr_o(IF_ID_instr_o), .IF_ID_valid_o(IF_ID_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: word 0 holds a load, every other address returns A500_0000 | addr.
  always_comb imem_data_i = (imem_addr_o == 32'h0) ? 32'h8C01_0004 : (32'hA500_0000 | imem_addr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; PC_write_i = 1'b1; IF_ID_write_i = 1'b1;
    flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".pc"},    imem_addr_o,   pc);
    check({tag, ".instr"}, IF_ID_instr_o, instr);
    check({tag, ".pc4"},   IF_ID_pc4_o,   pc4);
    check({tag, ".valid"}, 32'(IF_ID_valid_o), 32'(valid));
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick(); tick();
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset.stall_cnt", 32'(stall_cnt_o), 32'h0);
    check("reset.flush_cnt", 32'(flush_cnt_o), 32'h0);

    rst_i = 1'b0;
    tick();
    check_ifid("idle_norun", 32'h0, 32'h0, 32'h0, 1'b0);

    // Arm and fetch the first instruction on the same edge.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_ifid("first_fetch", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
    tick();
    check_ifid("seq_fetch", 32'h8, 32'hA500_0004, 32'h8, 1'b1);

    // Load-use stall at PC=8.
    PC_write_i = 1'b0; IF_ID_write_i = 1'b0;
    tick();
    check_ifid("stall", 32'h8, 32'hA500_0004, 32'h8, 1'b1);
    check("stall.stall_cnt", 32'(stall_cnt_o), 32'(PERF));
    idle_inputs();
    tick();
    check_ifid("post_stall", 32'hC, 32'hA500_0008, 32'hC, 1'b1);

    // Redirect with flush, unaligned target.
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0043; flush_i = 1'b1;
    tick();
    check_ifid("redirect", 32'h40, 32'h0, 32'h0, 1'b0);
    check("redirect.flush_cnt", 32'(flush_cnt_o), 32'(PERF));
    idle_inputs();
    tick();
    check_ifid("target_fetch", 32'h44, 32'hA500_0040, 32'h44, 1'b1);

    // Flush beats IF/ID hold.
    flush_i = 1'b1; IF_ID_write_i = 1'b0;
    tick();
    check_ifid("flush_vs_hold", 32'h48, 32'h0, 32'h0, 1'b0);
    check("flush_vs_hold.flush_cnt", 32'(flush_cnt_o), 32'(2 * PERF));
    idle_inputs();
    tick();
    check_ifid("post_flush", 32'h4C, 32'hA500_0048, 32'h4C, 1'b1);

    // PC wraparound at top of address space.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    check_ifid("to_top", 32'hFFFF_FFFC, 32'hA500_004C, 32'h50, 1'b1);
    idle_inputs();
    tick();
    check_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Reset in the middle of a stall at PC=0x20.
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0020;
    tick();
    check("goto_20.pc", imem_addr_o, 32'h20);
    idle_inputs();
    PC_write_i = 1'b0; IF_ID_write_i = 1'b0;
    tick();
    check("stall_20.pc", imem_addr_o, 32'h20);
    check("stall_20.stall_cnt", 32'(stall_cnt_o), 32'(2 * PERF));
    rst_i = 1'b1;
    tick();
    check_ifid("rst_mid_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst_mid_stall.stall_cnt", 32'(stall_cnt_o), 32'h0);
    check("rst_mid_stall.flush_cnt", 32'(flush_cnt_o), 32'h0);
    rst_i = 1'b0;
    idle_inputs();
    tick(); tick();
    check_ifid("no_restart", 32'h0, 32'h0, 32'h0, 1'b0);
    start_i = 1'b1;
    tick();
    idle_inputs();
    check_ifid("restart", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);

    // Flush counter saturates at all-ones.
    flush_i = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    idle_inputs();
    check("flush_sat.flush_cnt", 32'(flush_cnt_o), 32'(PERF * 7));
    check("flush_sat.valid", 32'(IF_ID_valid_o), 32'h0);
    check("flush_sat.pc", imem_addr_o, 32'h28);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
